// File: rtl/accel_uart_cmd_ctrl.sv
// Accelerometer-to-UART readout sequencer: decodes axis commands, waits for settled data, sends each sample low byte first.
// Define ACCEL_UART_CHECKSUM_EN to append a third byte (low XOR high) after each sample.
module accel_uart_cmd_ctrl #(
  parameter int SETTLE_CYCLES = 50000,
  parameter int ACK_TIMEOUT   = 8,
  parameter int SETTLE_W      = 16
) (
  input  logic        CLK_50,
  input  logic        iRSTN,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [15:0] accel_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [1:0]  dimension,
  output logic        ctrl_busy,
  output logic        cmd_err,
  output logic [7:0]  drop_cnt
);
  // state   | meaning
  // IDLE    | accepting command bytes
  // SETTLE  | waiting for the newly selected axis to produce fresh data
  // SEND_*  | waiting for an idle transmitter, then issuing tx_start
  // ACK_*   | waiting for tx_busy to rise (bounded by ACK_TIMEOUT)
  // DONE_*  | waiting for the byte to finish
  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_SEND_LO, S_ACK_LO, S_DONE_LO, S_SEND_HI, S_ACK_HI, S_DONE_HI
`ifdef ACCEL_UART_CHECKSUM_EN
    , S_SEND_CK, S_ACK_CK, S_DONE_CK
`endif
  } state_t;

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  state_t              r_state, w_next;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [ACK_W-1:0]    r_ack_cnt;
  logic [15:0]         r_sample;
  logic                r_sweep;
  logic                r_tx_start, r_ctrl_busy, r_cmd_err;
  logic [7:0]          r_tx_data, r_drop_cnt;
  logic [1:0]          r_dimension;

  logic       w_send, w_capture, w_cmd_ok, w_cmd_bad, w_cmd_sweep;
  logic       w_end_axis, w_next_axis, w_in_ack, w_ack_to;
  logic [7:0] w_send_byte;
  logic [1:0] w_cmd_dim;

  assign w_ack_to = (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1));

  always_comb begin
    w_next      = r_state;
    w_send      = 1'b0;
    w_send_byte = 8'h00;
    w_capture   = 1'b0;
    w_cmd_ok    = 1'b0;
    w_cmd_bad   = 1'b0;
    w_cmd_sweep = 1'b0;
    w_cmd_dim   = r_dimension;
    w_end_axis  = 1'b0;
    w_in_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h78:   begin w_cmd_ok = 1'b1; w_cmd_dim = 2'd0; end
            8'h79:   begin w_cmd_ok = 1'b1; w_cmd_dim = 2'd1; end
            8'h7A:   begin w_cmd_ok = 1'b1; w_cmd_dim = 2'd2; end
            8'h61:   begin w_cmd_ok = 1'b1; w_cmd_dim = 2'd0; w_cmd_sweep = 1'b1; end
            default: w_cmd_bad = 1'b1;
          endcase
        end
        if (w_cmd_ok) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          w_capture = 1'b1;
          w_next    = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        if (!tx_busy) begin
          w_send      = 1'b1;
          w_send_byte = r_sample[7:0];
          w_next      = S_ACK_LO;
        end
      end
      S_ACK_LO: begin
        w_in_ack = 1'b1;
        if (tx_busy || w_ack_to) w_next = S_DONE_LO;
      end
      S_DONE_LO: if (!tx_busy) w_next = S_SEND_HI;
      S_SEND_HI: begin
        if (!tx_busy) begin
          w_send      = 1'b1;
          w_send_byte = r_sample[15:8];
          w_next      = S_ACK_HI;
        end
      end
      S_ACK_HI: begin
        w_in_ack = 1'b1;
        if (tx_busy || w_ack_to) w_next = S_DONE_HI;
      end
`ifdef ACCEL_UART_CHECKSUM_EN
      S_DONE_HI: if (!tx_busy) w_next = S_SEND_CK;
      S_SEND_CK: begin
        if (!tx_busy) begin
          w_send      = 1'b1;
          w_send_byte = r_sample[7:0] ^ r_sample[15:8];
          w_next      = S_ACK_CK;
        end
      end
      S_ACK_CK: begin
        w_in_ack = 1'b1;
        if (tx_busy || w_ack_to) w_next = S_DONE_CK;
      end
      S_DONE_CK: if (!tx_busy) w_end_axis = 1'b1;
`else
      S_DONE_HI: if (!tx_busy) w_end_axis = 1'b1;
`endif
      default: w_next = S_IDLE;
    endcase
    w_next_axis = w_end_axis && r_sweep && (r_dimension != 2'd2);
    if (w_end_axis) w_next = w_next_axis ? S_SETTLE : S_IDLE;
  end

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_ack_cnt    <= '0;
      r_sample     <= 16'h0000;
      r_sweep      <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_dimension  <= 2'd0;
      r_ctrl_busy  <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_drop_cnt   <= 8'h00;
    end else begin
      r_state     <= w_next;
      r_ctrl_busy <= (w_next != S_IDLE);
      r_tx_start  <= w_send;
      r_cmd_err   <= w_cmd_bad;
      if (w_send) r_tx_data <= w_send_byte;
      if (w_capture) r_sample <= accel_data;
      // counters only run while staying in their state, so every entry starts from zero
      r_settle_cnt <= (r_state == S_SETTLE && w_next == S_SETTLE) ? r_settle_cnt + 1'b1 : '0;
      r_ack_cnt    <= (w_in_ack && w_next == r_state) ? r_ack_cnt + 1'b1 : '0;
      if (w_cmd_ok) begin
        r_dimension <= w_cmd_dim;
        r_sweep     <= w_cmd_sweep;
      end else if (w_next_axis) begin
        r_dimension <= r_dimension + 2'd1;
      end else if (w_end_axis) begin
        r_sweep <= 1'b0;
      end
      if (rx_valid && r_state != S_IDLE && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign dimension = r_dimension;
  assign ctrl_busy = r_ctrl_busy;
  assign cmd_err   = r_cmd_err;
  assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_accel_uart_cmd_ctrl.sv
// Scoreboard bench for accel_uart_cmd_ctrl: expected bytes are queued by the stimulus and popped by a tx monitor.
module tb_accel_uart_cmd_ctrl;
  localparam int SETTLE = 4;

  logic        CLK_50, iRSTN, rx_valid, tx_busy;
  logic [7:0]  rx_data;
  logic [15:0] accel_data;
  logic        tx_start, ctrl_busy, cmd_err;
  logic [7:0]  tx_data, drop_cnt;
  logic [1:0]  dimension;

  accel_uart_cmd_ctrl #(.SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(8), .SETTLE_W(16)) dut (
    .CLK_50(CLK_50), .iRSTN(iRSTN), .rx_valid(rx_valid), .rx_data(rx_data),
    .accel_data(accel_data), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .dimension(dimension), .ctrl_busy(ctrl_busy), .cmd_err(cmd_err), .drop_cnt(drop_cnt)
  );

  typedef struct {logic [7:0] data; logic [1:0] dim;} exp_t;
  exp_t exp_q[$];
  int   start_times[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, rx_cyc = 0, start_cnt = 0;
  int   busy_len = 10;
  bit   stuck = 0;

  initial begin
    CLK_50 = 0;
    forever #5 CLK_50 = ~CLK_50;
  end

  initial forever begin
    @(posedge CLK_50);
    cyc++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transmitter model: busy rises the cycle after tx_start and stays high busy_len cycles
  initial begin
    automatic int  left = 0;
    automatic bit  pend = 0;
    tx_busy = 0;
    forever begin
      @(negedge CLK_50);
      if (pend) begin
        tx_busy = 1; left = busy_len; pend = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 0;
      end
      if (tx_start && !stuck) pend = 1;
    end
  end

  // monitor: every tx_start pops one expected byte
  initial begin
    automatic bit   prev_start = 0;
    automatic exp_t e;
    forever begin
      @(posedge CLK_50);
      #1;
      if (tx_start) begin
        start_cnt++;
        start_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_tx: got byte 0x%0h, expected no transmission", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", tx_data, e.data);
          check("tx_dim", dimension, e.dim);
        end
        check("start_while_busy", tx_busy, 0);
        check("start_back_to_back", prev_start, 0);
      end
      prev_start = tx_start;
    end
  end

  task automatic expect_axis(input logic [15:0] s, input logic [1:0] d);
    exp_q.push_back('{s[7:0], d});
    exp_q.push_back('{s[15:8], d});
`ifdef ACCEL_UART_CHECKSUM_EN
    exp_q.push_back('{s[7:0] ^ s[15:8], d});
`endif
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge CLK_50);
    rx_valid = 1; rx_data = b; rx_cyc = cyc;
    @(negedge CLK_50);
    rx_valid = 0;
  endtask

  // follow_dim presents 0x1111 * (dimension+1) as the live axis sample
  task automatic wait_idle(input int max, input bit follow_dim);
    int n;
    n = 0;
    while (ctrl_busy && n < max) begin
      @(negedge CLK_50);
      if (follow_dim) accel_data = 16'h1111 * (16'(dimension) + 16'd1);
      n++;
    end
    if (ctrl_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got ctrl_busy=1 after %0d cycles, expected 0", max);
    end
  endtask

  initial begin
    int idx, s0, n;
    iRSTN = 0; rx_valid = 0; rx_data = 0; accel_data = 0;
    repeat (3) @(negedge CLK_50);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_dimension", dimension, 0);
    check("rst_ctrl_busy", ctrl_busy, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    iRSTN = 1;
    repeat (2) @(negedge CLK_50);

    // single axis 'y'
    accel_data = 16'hA1B2;
    expect_axis(16'hA1B2, 2'd1);
    idx = start_times.size();
    send_rx(8'h79);
    check("busy_after_cmd", ctrl_busy, 1);
    wait_idle(500, 0);
    if (start_times.size() > idx) check("first_start_latency", start_times[idx] - rx_cyc, SETTLE + 2);
    else begin n_cmp++; n_bad++; $display("FAIL first_start_latency: got no tx_start, expected one"); end
    check("y_dimension", dimension, 1);
    check("y_queue_empty", exp_q.size(), 0);

    // sweep
    for (int d = 0; d < 3; d++) expect_axis(16'h1111 * 16'(d + 1), 2'(d));
    accel_data = 16'h1111;
    send_rx(8'h61);
    wait_idle(2000, 1);
    check("sweep_final_dim", dimension, 2);
    check("sweep_queue_empty", exp_q.size(), 0);

    // unrecognised byte
    s0 = start_cnt;
    send_rx(8'h51);
    check("cmd_err_pulse", cmd_err, 1);
    @(negedge CLK_50);
    check("cmd_err_clear", cmd_err, 0);
    repeat (10) @(negedge CLK_50);
    check("bad_no_start", start_cnt - s0, 0);
    check("bad_dim_kept", dimension, 2);
    check("bad_not_busy", ctrl_busy, 0);

    // drops during a transfer
    accel_data = 16'h5566;
    expect_axis(16'h5566, 2'd0);
    send_rx(8'h78);
    repeat (3) send_rx(8'h79);
    wait_idle(500, 0);
    check("drop_cnt_3", drop_cnt, 3);
    check("drop_dim_kept", dimension, 0);
    check("drop_queue_empty", exp_q.size(), 0);

    busy_len = 200;
    expect_axis(16'h5566, 2'd0);
    send_rx(8'h78);
    rx_data = 8'h51; rx_valid = 1;
    repeat (257) @(negedge CLK_50);
    rx_valid = 0;
    wait_idle(3000, 0);
    check("drop_cnt_sat", drop_cnt, 255);
    check("sat_queue_empty", exp_q.size(), 0);
    busy_len = 10;

    // stuck transmitter: ack timeouts
    stuck = 1;
    accel_data = 16'h0F0E;
    expect_axis(16'h0F0E, 2'd2);
    idx = start_times.size();
    send_rx(8'h7A);
    wait_idle(500, 0);
`ifdef ACCEL_UART_CHECKSUM_EN
    check("stuck_start_count", start_times.size() - idx, 3);
`else
    check("stuck_start_count", start_times.size() - idx, 2);
`endif
    if (start_times.size() >= idx + 2) check("stuck_start_gap", start_times[idx+1] - start_times[idx], 10);
    check("stuck_queue_empty", exp_q.size(), 0);
    stuck = 0;

    // reset while waiting for the low byte to finish
    accel_data = 16'hA1B2;
    expect_axis(16'hA1B2, 2'd1);
    s0 = start_cnt;
    send_rx(8'h79);
    n = 0;
    while (start_cnt == s0 && n < 50) begin @(negedge CLK_50); n++; end
    check("pre_reset_start", start_cnt - s0, 1);
    repeat (3) @(negedge CLK_50);
    #2 iRSTN = 0;
    #1;
    check("async_tx_start", tx_start, 0);
    check("async_tx_data", tx_data, 0);
    check("async_dimension", dimension, 0);
    check("async_ctrl_busy", ctrl_busy, 0);
    check("async_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    repeat (2) @(negedge CLK_50);
    iRSTN = 1;
    n = 0;
    while (tx_busy && n < 50) begin @(negedge CLK_50); n++; end
    check("frame_finished", tx_busy, 0);
    accel_data = 16'h1234;
    expect_axis(16'h1234, 2'd2);
    send_rx(8'h7A);
    wait_idle(500, 0);
    check("post_reset_dim", dimension, 2);
    check("post_reset_queue_empty", exp_q.size(), 0);

    repeat (5) @(negedge CLK_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/accel_uart_cmd_ctrl.md
Name: accel_uart_cmd_ctrl

Overview:
- Sequences the accelerometer-to-UART readout path: decodes single-byte commands from the UART receiver and drives the axis select into the SPI accelerometer config block.
- Waits for fresh axis data, then streams the 16-bit sample to the UART transmitter as two bytes, low byte first, using a proper start/busy handshake.
- Sits between async_receiver/async_transmitter and spi_ee_config in the serial top level, replacing its ad-hoc combinational send logic.

Parameters:
- SETTLE_CYCLES, 50000, CLK_50 cycles to wait after a dimension change before sampling data (1 ms at 50 MHz); minimum 1.
- ACK_TIMEOUT, 8, max cycles to wait for tx_busy to rise after a tx_start pulse.
- SETTLE_W, 16, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- CLK_50  in  1  system clock, 50 MHz
- iRSTN  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle pulse, rx_data is valid (RxD_data_ready)
- rx_data  in  8  received command byte
- accel_data  in  16  current axis sample from spi_ee_config ({oDATA_H, oDATA_L})
- tx_busy  in  1  transmitter busy
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit; held stable from the tx_start cycle until tx_busy falls
- dimension  out  2  axis select to spi_ee_config: 0=x, 1=y, 2=z
- ctrl_busy  out  1  high whenever state != IDLE
- cmd_err  out  1  one-cycle pulse on an unrecognised command byte
- drop_cnt  out  8  saturating count of commands dropped while busy

Behaviour:
- Reset (iRSTN low, async): state=IDLE, tx_start=0, tx_data=0, dimension=0, cmd_err=0, drop_cnt=0, settle counter=0, sample register=0, axis-sweep flag=0. All outputs are registered.
- Command decode (IDLE only):
  - 0x78 'x' selects dimension 0; 0x79 'y' selects 1; 0x7A 'z' selects 2.
  - 0x61 'a' starts a sweep: sets dimension=0 and the sweep flag.
  - Any other byte: cmd_err pulses for 1 cycle; dimension and state are unchanged.
- States:
  - IDLE: on rx_valid with a valid command, latch dimension, clear the settle counter, and go to SETTLE on the next edge.
  - SETTLE: count up to SETTLE_CYCLES-1, then capture accel_data into the sample register and go to SEND_LO.
  - SEND_LO: when tx_busy=0, drive tx_data=sample[7:0], pulse tx_start for 1 cycle, and go to ACK_LO. While tx_busy=1, hold in SEND_LO with tx_start=0.
  - ACK_LO: wait for tx_busy=1, then go to DONE_LO. If tx_busy stays low for ACK_TIMEOUT cycles, go to DONE_LO anyway.
  - DONE_LO: wait for tx_busy=0, then go to SEND_HI.
  - SEND_HI, ACK_HI, DONE_HI: same handshake using sample[15:8].
  - After DONE_HI:
    - Sweep flag set and dimension<2: increment dimension and go to SETTLE.
    - Sweep flag set and dimension==2: clear the flag and go to IDLE.
    - No sweep: go to IDLE.
- Latency: a single-axis command produces the first tx_start exactly SETTLE_CYCLES+2 cycles after the rx_valid cycle when tx_busy=0.
- rx_valid outside IDLE: the byte is ignored, does not alter dimension, and drop_cnt increments, saturating at 255. rx_valid in the same cycle as the return to IDLE is also dropped.
- tx_start is never asserted while tx_busy=1. tx_start is never high on two consecutive cycles.
- The sample is captured once per axis, so both bytes always come from the same 16-bit sample (no tearing).
- Reset mid-transfer returns to IDLE immediately. A UART frame already in flight is not aborted; the transmitter finishes it.

Optional Feature:
- Macro: ACCEL_UART_CHECKSUM_EN.
- Defined: after DONE_HI, the block adds states SEND_CK/ACK_CK/DONE_CK, which transmit a third byte equal to sample[7:0] XOR sample[15:8] using the same handshake. Sweep sequencing continues after DONE_CK.
- Undefined: exactly two bytes per axis; no extra states are synthesised.

Test Plan:
- SETTLE_CYCLES=4, tx_busy model asserts 1 cycle after start and lasts 10 cycles. rx 0x79, accel_data=0xA1B2 -> dimension=1; tx bytes 0xB2 then 0xA1; first tx_start at cycle 6 after rx_valid; ctrl_busy returns to 0.
- rx 0x61 with accel_data=0x1111/0x2222/0x3333 presented per dimension -> dimension steps 0,1,2; 6 bytes sent: 11 11 22 22 33 33; final dimension=2.
- rx 0x51 in IDLE -> cmd_err 1-cycle pulse, no tx_start, dimension unchanged.
- Three rx_valid pulses during a transfer -> drop_cnt=3, output byte stream unchanged; 260 drops -> drop_cnt=255.
- tx_busy never rises (stuck transmitter, busy held 0) -> each ACK state exits after 8 cycles; exactly two tx_start pulses; controller returns to IDLE.
- iRSTN low during DONE_LO -> all outputs reset asynchronously. After release, rx 0x7A -> normal two-byte transfer. With ACCEL_UART_CHECKSUM_EN and accel_data=0xA1B2 -> third byte 0x13.
